// File: rtl/ieee754_sub_seq.sv
// rtl/ieee754_sub_seq.sv - multi-cycle IEEE754 single-precision subtractor (truncating, flush-to-zero)
module ieee754_sub_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        PACK  = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_r, b_r;
    logic [7:0]       exp_r;
    logic [23:0]      man_l, man_s;
    logic             sign_l, sign_s;
    logic [24:0]      sum_r;
    logic             zero_r;
    logic [WIDTH-1:0] result_r;
    logic             done_r;

    // Operand decode; b's sign is flipped so the datapath only ever adds
    logic [7:0]  exp_a, exp_b, exp_big, exp_diff;
    logic [23:0] man_a, man_b, man_big, man_small, man_shifted;
    logic        sgn_a, sgn_b, a_is_big;

    always_comb begin
        exp_a    = a_r[30:23];
        exp_b    = b_r[30:23];
        man_a    = (exp_a == 8'd0) ? 24'd0 : {1'b1, a_r[22:0]};
        man_b    = (exp_b == 8'd0) ? 24'd0 : {1'b1, b_r[22:0]};
        sgn_a    = a_r[31];
        sgn_b    = ~b_r[31];
        a_is_big = ({exp_a, man_a} >= {exp_b, man_b});
        exp_big  = a_is_big ? exp_a : exp_b;
        man_big  = a_is_big ? man_a : man_b;
        man_small = a_is_big ? man_b : man_a;
        exp_diff = a_is_big ? (exp_a - exp_b) : (exp_b - exp_a);
        man_shifted = (exp_diff > 8'd24) ? 24'd0 : (man_small >> exp_diff);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = ALIGN;
            ALIGN: state_nxt = ADD;
            ADD:   state_nxt = NORM;
            NORM: begin
                if (sum_r == 25'd0 || sum_r[24] || sum_r[23] || exp_r <= 8'd1)
                    state_nxt = PACK;
            end
            PACK:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r      <= '0;
            b_r      <= '0;
            exp_r    <= '0;
            man_l    <= '0;
            man_s    <= '0;
            sign_l   <= 1'b0;
            sign_s   <= 1'b0;
            sum_r    <= '0;
            zero_r   <= 1'b0;
            result_r <= '0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r <= in_a;
                        b_r <= in_b;
                    end
                end
                ALIGN: begin
                    exp_r  <= exp_big;
                    man_l  <= man_big;
                    man_s  <= man_shifted;
                    sign_l <= a_is_big ? sgn_a : sgn_b;
                    sign_s <= a_is_big ? sgn_b : sgn_a;
                    zero_r <= 1'b0;
                end
                ADD: begin
                    if (sign_l == sign_s)
                        sum_r <= {1'b0, man_l} + {1'b0, man_s};
                    else
                        sum_r <= {1'b0, man_l} - {1'b0, man_s};
                end
                NORM: begin
                    if (sum_r == 25'd0) begin
                        zero_r <= 1'b1;
                    end else if (sum_r[24]) begin
                        sum_r <= sum_r >> 1;
                        if (exp_r != 8'hff)
                            exp_r <= exp_r + 8'd1;
                    end else if (sum_r[23]) begin
                        zero_r <= zero_r;
                    end else if (exp_r <= 8'd1) begin
                        // The next left shift would take the exponent to 0
                        zero_r <= 1'b1;
                    end else begin
                        sum_r <= sum_r << 1;
                        exp_r <= exp_r - 8'd1;
                    end
                end
                PACK: begin
                    done_r <= 1'b1;
                    if (zero_r)
                        result_r <= '0;
                    else if (exp_r == 8'hff)
                        result_r <= {sign_l, 8'hff, 23'd0};
                    else
                        result_r <= {sign_l, exp_r, sum_r[22:0]};
                end
                default: done_r <= 1'b0;
            endcase
        end
    end

    assign done   = done_r;
    assign result = result_r;

endmodule

// File: tb/tb_ieee754_sub_seq.sv
// tb/tb_ieee754_sub_seq.sv - scoreboard bench for ieee754_sub_seq
module tb_ieee754_sub_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] in_a, in_b;
    logic        busy, done;
    logic [31:0] result;

    ieee754_sub_seq #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .in_a   (in_a),
        .in_b   (in_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   finished = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Driver: called at a negedge, leaves one negedge later with start low
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input int lat, input bit push);
        exp_t e;
        start = 1'b1;
        in_a  = a;
        in_b  = b;
        if (push) begin
            e.res = r;
            e.lat = lat;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    // Monitor samples 1 time unit after each negedge
    int cyc = 0;
    int accept_cyc = 0;
    int busy_cnt = 0;
    bit pending = 0;
    bit prev_done = 0;

    always begin
        exp_t e;
        @(negedge clk);
        #1;
        cyc++;
        if (!rst_n) begin
            pending  = 0;
            busy_cnt = 0;
            prev_done = 0;
        end else begin
            if (prev_done)
                check("done_single_pulse", {31'd0, done}, 32'd0);
            if (done && !prev_done) begin
                if (sb.size() == 0 || !pending) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("result", result, e.res);
                    check("latency", cyc - accept_cyc - 1, e.lat);
                    check("busy_cycles", busy_cnt, e.lat);
                    pending = 0;
                end
            end
            prev_done = done;
            if (start && !busy) begin
                accept_cyc = cyc;
                busy_cnt   = 0;
                pending    = 1;
            end else if (busy) begin
                busy_cnt++;
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        in_a  = '0;
        in_b  = '0;
        repeat (3) @(negedge clk);
        #2;
        check("reset_busy",   {31'd0, busy}, 32'd0);
        check("reset_done",   {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 3.0 - 1.0, immediately followed back-to-back by 1.0 - (-1.0)
        issue(32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 4, 1);
        repeat (4) @(negedge clk);
        issue(32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000, 4, 1);
        repeat (6) @(negedge clk);

        // 1.0 - 1.0 gives +0
        issue(32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 4, 1);
        repeat (6) @(negedge clk);

        // 1.0 - 0.75, two left shifts
        issue(32'h3F80_0000, 32'h3F40_0000, 32'h3E80_0000, 6, 1);
        repeat (8) @(negedge clk);

        // exponent difference 24 truncates S away; start while busy is ignored
        issue(32'h4B80_0000, 32'h3F80_0000, 32'h4B80_0000, 4, 1);
        start = 1'b1;
        in_a  = 32'h4040_0000;
        in_b  = 32'h3F80_0000;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);

        // -2.0 - 1.0 = -3.0
        issue(32'hC000_0000, 32'h3F80_0000, 32'hC040_0000, 4, 1);
        repeat (7) @(negedge clk);

        // Reset during NORM of 1.0 - 0.75: discarded, outputs cleared at once
        issue(32'h3F80_0000, 32'h3F40_0000, 32'h0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        check("async_rst_busy",   {31'd0, busy}, 32'd0);
        check("async_rst_done",   {31'd0, done}, 32'd0);
        check("async_rst_result", result, 32'd0);
        repeat (3) @(negedge clk);
        check("rst_hold_result", result, 32'd0);
        rst_n = 1'b1;
        issue(32'h3F80_0000, 32'h3F40_0000, 32'h3E80_0000, 6, 1);
        repeat (12) @(negedge clk);

        check("scoreboard_empty", sb.size(), 32'd0);
        finished = 1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #20000;
        if (!finished) begin
            $display("FAIL timeout: got running, expected finished");
            $fatal(1);
        end
    end

endmodule
